l1_l2_request_queue: RTL and testbench

- Downstream stage of the split L1 cache; carries L1 miss traffic to L2.
- Takes instruction-cache read misses and data-cache read, write-through and write-back requests.
- Arbitrates round-robin between the two sources and buffers requests in an in-order FIFO.
- Presents the FIFO head to L2 through a valid/ready handshake.

---
 rtl/l1_l2_request_queue.sv | 169 ++++++++++++++++
 tb/tb_l1_l2_request_queue.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/l1_l2_request_queue.sv
// L1-miss to L2 request queue: round-robin I/D arbitration into an in-order FIFO.
// Define L1_L2_QUEUE_STATS_EN to build the saturating dequeue statistics counters.
module l1_l2_request_queue #(
    parameter int ADDRESS_WIDTH     = 32,
    parameter int BYTE_SELECT_WIDTH = 6,
    parameter int DEPTH             = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     i_req_valid,
    input  logic [ADDRESS_WIDTH-1:0] i_req_addr,
    output logic                     i_req_ready,
    input  logic                     d_req_valid,
    input  logic [1:0]               d_req_op,
    input  logic [ADDRESS_WIDTH-1:0] d_req_addr,
    output logic                     d_req_ready,
    output logic                     l2_req_valid,
    input  logic                     l2_req_ready,
    output logic [1:0]               l2_req_op,
    output logic [ADDRESS_WIDTH-1:0] l2_req_addr,
    output logic                     l2_req_src,
    output logic                     err_illegal_op,
    output logic [$clog2(DEPTH):0]   count,
    output logic [31:0]              stat_i_reads,
    output logic [31:0]              stat_d_reads,
    output logic [31:0]              stat_writes,
    output logic [31:0]              stat_writebacks
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [ADDRESS_WIDTH-1:0] LINE_MASK =
        {ADDRESS_WIDTH{1'b1}} << BYTE_SELECT_WIDTH;

    logic [PW-1:0] wr_q, wr_d, rd_q, rd_d;
    logic [CW-1:0] count_q, count_d;
    logic          last_data_q, last_data_d;
    logic          err_q, err_d;

    logic [1:0]               op_mem   [DEPTH];
    logic [ADDRESS_WIDTH-1:0] addr_mem [DEPTH];
    logic                     src_mem  [DEPTH];

    logic                     full, gnt_i, gnt_d;
    logic                     illegal, enq, deq;
    logic [1:0]               enq_op;
    logic [ADDRESS_WIDTH-1:0] enq_addr;

    assign full = (count_q == CW'(DEPTH));

    // Grants are held low while in reset so ready never leaks out.
    always_comb begin
        gnt_i = 1'b0;
        gnt_d = 1'b0;
        if (rst_n && !flush && !full) begin
            if (i_req_valid && d_req_valid) begin
                gnt_i = last_data_q;
                gnt_d = !last_data_q;
            end else begin
                gnt_i = i_req_valid;
                gnt_d = d_req_valid;
            end
        end
    end

    assign i_req_ready = gnt_i;
    assign d_req_ready = gnt_d;
    assign illegal     = gnt_d && (d_req_op == 2'b11);
    assign enq         = (gnt_i || gnt_d) && !illegal;
    assign deq         = (count_q != '0) && l2_req_ready && !flush;
    assign enq_op      = gnt_d ? d_req_op : 2'b00;
    assign enq_addr    = (gnt_d ? d_req_addr : i_req_addr) & LINE_MASK;

    always_comb begin
        wr_d        = wr_q;
        rd_d        = rd_q;
        count_d     = count_q;
        last_data_d = last_data_q;
        err_d       = 1'b0;
        if (flush) begin
            wr_d        = '0;
            rd_d        = '0;
            count_d     = '0;
            last_data_d = 1'b1;
        end else begin
            if (gnt_i || gnt_d) last_data_d = gnt_d;
            err_d = illegal;
            if (enq) wr_d = wr_q + PW'(1);
            if (deq) rd_d = rd_q + PW'(1);
            if (enq && !deq)      count_d = count_q + CW'(1);
            else if (!enq && deq) count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_q        <= '0;
            rd_q        <= '0;
            count_q     <= '0;
            last_data_q <= 1'b1;
            err_q       <= 1'b0;
        end else begin
            wr_q        <= wr_d;
            rd_q        <= rd_d;
            count_q     <= count_d;
            last_data_q <= last_data_d;
            err_q       <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            op_mem[wr_q]   <= enq_op;
            addr_mem[wr_q] <= enq_addr;
            src_mem[wr_q]  <= gnt_d;
        end
    end

    assign l2_req_valid   = (count_q != '0);
    assign l2_req_op      = op_mem[rd_q];
    assign l2_req_addr    = addr_mem[rd_q];
    assign l2_req_src     = src_mem[rd_q];
    assign err_illegal_op = err_q;
    assign count          = count_q;

`ifdef L1_L2_QUEUE_STATS_EN
    logic [31:0] st_ir_q, st_dr_q, st_wr_q, st_wb_q;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == '1) ? v : v + 32'd1;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st_ir_q <= '0;
            st_dr_q <= '0;
            st_wr_q <= '0;
            st_wb_q <= '0;
        end else if (flush) begin
            st_ir_q <= '0;
            st_dr_q <= '0;
            st_wr_q <= '0;
            st_wb_q <= '0;
        end else if (deq) begin
            case (l2_req_op)
                2'b00: begin
                    if (l2_req_src) st_dr_q <= sat_inc(st_dr_q);
                    else            st_ir_q <= sat_inc(st_ir_q);
                end
                2'b01:   st_wr_q <= sat_inc(st_wr_q);
                2'b10:   st_wb_q <= sat_inc(st_wb_q);
                default: ;
            endcase
        end
    end

    assign stat_i_reads    = st_ir_q;
    assign stat_d_reads    = st_dr_q;
    assign stat_writes     = st_wr_q;
    assign stat_writebacks = st_wb_q;
`else
    assign stat_i_reads    = '0;
    assign stat_d_reads    = '0;
    assign stat_writes     = '0;
    assign stat_writebacks = '0;
`endif

endmodule

// File: tb/tb_l1_l2_request_queue.sv
// Bench for l1_l2_request_queue: vector table for grants/count, scoreboard for L2 heads.
// Honours L1_L2_QUEUE_STATS_EN for the statistics checks.
module tb_l1_l2_request_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        i_req_valid;
    logic [31:0] i_req_addr;
    logic        i_req_ready;
    logic        d_req_valid;
    logic [1:0]  d_req_op;
    logic [31:0] d_req_addr;
    logic        d_req_ready;
    logic        l2_req_valid;
    logic        l2_req_ready;
    logic [1:0]  l2_req_op;
    logic [31:0] l2_req_addr;
    logic        l2_req_src;
    logic        err_illegal_op;
    logic [3:0]  count;
    logic [31:0] stat_i_reads, stat_d_reads, stat_writes, stat_writebacks;

    always #5 clk = ~clk;

    l1_l2_request_queue #(
        .ADDRESS_WIDTH(32),
        .BYTE_SELECT_WIDTH(6),
        .DEPTH(8)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .flush(flush),
        .i_req_valid(i_req_valid),
        .i_req_addr(i_req_addr),
        .i_req_ready(i_req_ready),
        .d_req_valid(d_req_valid),
        .d_req_op(d_req_op),
        .d_req_addr(d_req_addr),
        .d_req_ready(d_req_ready),
        .l2_req_valid(l2_req_valid),
        .l2_req_ready(l2_req_ready),
        .l2_req_op(l2_req_op),
        .l2_req_addr(l2_req_addr),
        .l2_req_src(l2_req_src),
        .err_illegal_op(err_illegal_op),
        .count(count),
        .stat_i_reads(stat_i_reads),
        .stat_d_reads(stat_d_reads),
        .stat_writes(stat_writes),
        .stat_writebacks(stat_writebacks)
    );

    typedef struct {
        logic        iv;
        logic [31:0] ia;
        logic        dv;
        logic [1:0]  dop;
        logic [31:0] da;
        logic        rdy;
        logic        fl;
        logic        eir;
        logic        edr;
        int          ecnt;
        logic        eerr;
    } vec_t;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] addr;
        logic        src;
    } ent_t;

    vec_t tbl[$];
    ent_t sb[$];
    int   n_chk = 0;
    int   n_err = 0;
    int   prev_cnt = 0;
    int   m_ir = 0, m_dr = 0, m_wr = 0, m_wb = 0;

    task automatic chk(input string nm, input logic [63:0] act,
                       input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, required 0x%0h", nm, act, exp);
        end
    endtask

    task automatic chk_stats();
`ifdef L1_L2_QUEUE_STATS_EN
        chk("stat_i_reads", 64'(stat_i_reads), 64'(m_ir));
        chk("stat_d_reads", 64'(stat_d_reads), 64'(m_dr));
        chk("stat_writes", 64'(stat_writes), 64'(m_wr));
        chk("stat_writebacks", 64'(stat_writebacks), 64'(m_wb));
`else
        chk("stat_i_reads", 64'(stat_i_reads), 64'd0);
        chk("stat_d_reads", 64'(stat_d_reads), 64'd0);
        chk("stat_writes", 64'(stat_writes), 64'd0);
        chk("stat_writebacks", 64'(stat_writebacks), 64'd0);
`endif
    endtask

    task automatic clear_model();
        sb.delete();
        m_ir = 0;
        m_dr = 0;
        m_wr = 0;
        m_wb = 0;
    endtask

    task automatic add(input logic iv, input logic [31:0] ia,
                       input logic dv, input logic [1:0] dop,
                       input logic [31:0] da, input logic rdy,
                       input logic fl, input logic eir, input logic edr,
                       input int ecnt, input logic eerr);
        vec_t v;
        v = '{iv, ia, dv, dop, da, rdy, fl, eir, edr, ecnt, eerr};
        tbl.push_back(v);
    endtask

    task automatic idle(input int ecnt);
        add(0, 0, 0, 2'b00, 0, 1, 0, 0, 0, ecnt, 0);
    endtask

    task automatic apply(input vec_t v);
        ent_t e;
        @(negedge clk);
        i_req_valid  = v.iv;
        i_req_addr   = v.ia;
        d_req_valid  = v.dv;
        d_req_op     = v.dop;
        d_req_addr   = v.da;
        l2_req_ready = v.rdy;
        flush        = v.fl;
        #2;
        chk("i_req_ready", 64'(i_req_ready), 64'(v.eir));
        chk("d_req_ready", 64'(d_req_ready), 64'(v.edr));
        chk("l2_req_valid", 64'(l2_req_valid), 64'(prev_cnt != 0));
        if (v.fl) begin
            clear_model();
        end else begin
            if (prev_cnt != 0 && v.rdy) begin
                if (sb.size() == 0) begin
                    n_chk++;
                    n_err++;
                    $display("FAIL scoreboard: dequeue with no entry expected");
                end else begin
                    e = sb.pop_front();
                    chk("l2_req_op", 64'(l2_req_op), 64'(e.op));
                    chk("l2_req_addr", 64'(l2_req_addr), 64'(e.addr));
                    chk("l2_req_src", 64'(l2_req_src), 64'(e.src));
                    case (e.op)
                        2'b00:   if (e.src) m_dr++; else m_ir++;
                        2'b01:   m_wr++;
                        2'b10:   m_wb++;
                        default: ;
                    endcase
                end
            end
            if (v.eir)
                sb.push_back('{op: 2'b00, addr: v.ia & 32'hFFFF_FFC0, src: 1'b0});
            else if (v.edr && v.dop != 2'b11)
                sb.push_back('{op: v.dop, addr: v.da & 32'hFFFF_FFC0, src: 1'b1});
        end
        @(posedge clk);
        #1;
        chk("count", 64'(count), 64'(v.ecnt));
        chk("err_illegal_op", 64'(err_illegal_op), 64'(v.eerr));
        chk_stats();
        prev_cnt = v.ecnt;
    endtask

    task automatic run_tbl();
        for (int k = 0; k < tbl.size(); k++) apply(tbl[k]);
        tbl.delete();
    endtask

    initial begin
        rst_n        = 1'b0;
        flush        = 1'b0;
        i_req_valid  = 1'b1;
        i_req_addr   = 32'h0000_0100;
        d_req_valid  = 1'b1;
        d_req_op     = 2'b00;
        d_req_addr   = 32'h0000_2000;
        l2_req_ready = 1'b1;
        #12;
        chk("rst i_req_ready", 64'(i_req_ready), 64'd0);
        chk("rst d_req_ready", 64'(d_req_ready), 64'd0);
        chk("rst l2_req_valid", 64'(l2_req_valid), 64'd0);
        chk("rst count", 64'(count), 64'd0);
        chk("rst err", 64'(err_illegal_op), 64'd0);
        chk_stats();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        // Tie after reset: I, D, I, D with L2 stalled, losers hold payload
        add(1, 32'h100, 1, 2'b00, 32'h2000, 0, 0, 1, 0, 1, 0);
        add(1, 32'h140, 1, 2'b00, 32'h2000, 0, 0, 0, 1, 2, 0);
        add(1, 32'h140, 1, 2'b01, 32'h3000, 0, 0, 1, 0, 3, 0);
        add(1, 32'h180, 1, 2'b01, 32'h3000, 0, 0, 0, 1, 4, 0);
        for (int k = 3; k >= 0; k--) idle(k);
        // Single I-read, aligned, one-cycle latency
        add(1, 32'h1234_567F, 0, 2'b00, 0, 1, 0, 1, 0, 1, 0);
        idle(0);
        // Fill to full with write-backs, then full refuses despite dequeue
        for (int k = 0; k < 8; k++)
            add(0, 0, 1, 2'b10, 32'h4007 + 32'(k * 64), 0, 0, 0, 1, k + 1, 0);
        add(1, 32'h5005, 1, 2'b00, 32'h6009, 1, 0, 0, 0, 7, 0);
        add(1, 32'h5005, 1, 2'b00, 32'h6009, 0, 0, 1, 0, 8, 0);
        for (int k = 7; k >= 0; k--) idle(k);
        // Illegal op: handshaken, not stored, one-cycle error pulse
        add(0, 0, 1, 2'b11, 32'hDEAD_BEEF, 1, 0, 0, 1, 0, 1);
        idle(0);
        // Flush with five queued and L2 ready
        for (int k = 0; k < 5; k++)
            add(0, 0, 1, 2'b00, 32'h8000 + 32'(k * 64), 0, 0, 0, 1, k + 1, 0);
        add(1, 32'h9000, 1, 2'b00, 32'hA000, 1, 1, 0, 0, 0, 0);
        idle(0);
        add(1, 32'h9000, 1, 2'b00, 32'hA000, 0, 0, 1, 0, 1, 0);
        add(1, 32'h9040, 1, 2'b00, 32'hA000, 0, 0, 0, 1, 2, 0);
        add(1, 32'h9040, 1, 2'b01, 32'hA040, 0, 0, 1, 0, 3, 0);
        run_tbl();

        // Asynchronous reset between edges with three entries queued
        #2;
        rst_n = 1'b0;
        #1;
        chk("async i_req_ready", 64'(i_req_ready), 64'd0);
        chk("async d_req_ready", 64'(d_req_ready), 64'd0);
        chk("async l2_req_valid", 64'(l2_req_valid), 64'd0);
        chk("async count", 64'(count), 64'd0);
        clear_model();
        prev_cnt = 0;
        chk_stats();
        i_req_valid = 1'b0;
        d_req_valid = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        add(1, 32'hB000, 1, 2'b00, 32'hC000, 0, 0, 1, 0, 1, 0);
        idle(0);
        run_tbl();

        if (sb.size() != 0) begin
            n_chk++;
            n_err++;
            $display("FAIL scoreboard: %0d entries never dequeued, required 0",
                     sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
